// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the unified-memory port arbiter.
package mem_arb_pkg;
    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 8;
    localparam int INSTR_W = 16;

    typedef logic [12:0] mem_addr_t;

    typedef enum logic [2:0] {
        IDLE,
        IF_HI,
        IF_LO,
        D_ACC,
        RESP
    } arb_state_t;
endpackage

// File: rtl/mem_arb_prio.sv
// Fetch/data priority decision with a starvation counter that forces a fetch
// after STARVE_MAX data grants won against a waiting fetch.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic arb_en,
    output logic gnt_if,
    output logic gnt_d
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_reg;
    logic             starved;

    assign starved = (starve_cnt_reg == CNT_W'(STARVE_MAX));
    assign gnt_if  = arb_en & if_req & (~d_req | starved);
    assign gnt_d   = arb_en & d_req & ~(if_req & starved);

    // The count only measures data wins while a fetch is actually waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_reg <= '0;
        end else if (!if_req || gnt_if) begin
            starve_cnt_reg <= '0;
        end else if (gnt_d) begin
            starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between 16-bit instruction fetch
// (two byte reads) and single-byte data loads/stores.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = mem_arb_pkg::ADDR_W,
    parameter int DATA_W     = mem_arb_pkg::DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic [2*DATA_W-1:0] if_instr,
    output logic                if_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wd,
    output logic                mem_write,
    output logic                mem_read,
    input  logic [DATA_W-1:0]   mem_rd,
    output logic                mem_rst,
    output logic                busy
);
    arb_state_t          state_reg, state_next;
    logic                last_if_reg;
    logic [ADDR_W-1:0]   if_addr_reg;
    logic [ADDR_W-1:0]   d_addr_reg;
    logic                d_we_reg;
    logic [DATA_W-1:0]   d_wdata_reg;
    logic [DATA_W-1:0]   d_rdata_reg;
    logic [2*DATA_W-1:0] if_instr_reg;
    logic                arb_en;
    logic                gnt_if, gnt_d;

    // Gating with rst keeps grants low while reset is asserted.
    assign arb_en = rst & ((state_reg == IDLE) || (state_reg == RESP));

    mem_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk    (clk),
        .rst    (rst),
        .if_req (if_req),
        .d_req  (d_req),
        .arb_en (arb_en),
        .gnt_if (gnt_if),
        .gnt_d  (gnt_d)
    );

    always_comb begin
        state_next = state_reg;
        mem_addr   = '0;
        mem_wd     = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state_reg)
            IDLE, RESP: begin
                if (gnt_if)     state_next = IF_HI;
                else if (gnt_d) state_next = D_ACC;
                else            state_next = IDLE;
            end
            IF_HI: begin
                mem_addr   = if_addr_reg;
                mem_read   = 1'b1;
                state_next = IF_LO;
            end
            IF_LO: begin
                mem_addr   = if_addr_reg + ADDR_W'(1);
                mem_read   = 1'b1;
                state_next = RESP;
            end
            D_ACC: begin
                mem_addr   = d_addr_reg;
                mem_read   = ~d_we_reg;
                mem_write  = d_we_reg;
                mem_wd     = d_we_reg ? d_wdata_reg : '0;
                state_next = RESP;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            last_if_reg  <= 1'b0;
            if_addr_reg  <= '0;
            d_addr_reg   <= '0;
            d_we_reg     <= 1'b0;
            d_wdata_reg  <= '0;
            d_rdata_reg  <= '0;
            if_instr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (gnt_if) begin
                last_if_reg <= 1'b1;
                if_addr_reg <= if_addr;
            end else if (gnt_d) begin
                last_if_reg <= 1'b0;
                d_addr_reg  <= d_addr;
                d_we_reg    <= d_we;
                d_wdata_reg <= d_wdata;
            end
            if (state_reg == IF_HI) if_instr_reg[2*DATA_W-1:DATA_W] <= mem_rd;
            if (state_reg == IF_LO) if_instr_reg[DATA_W-1:0]        <= mem_rd;
            if (state_reg == D_ACC && !d_we_reg) d_rdata_reg <= mem_rd;
        end
    end

    // RESP serves whichever access just finished, remembered in last_if_reg.
    assign if_gnt   = gnt_if;
    assign d_gnt    = gnt_d;
    assign if_valid = (state_reg == RESP) & last_if_reg;
    assign d_valid  = (state_reg == RESP) & ~last_if_reg;
    assign if_instr = if_instr_reg;
    assign d_rdata  = d_rdata_reg;
    assign busy     = (state_reg != IDLE);
    assign mem_rst  = ~rst;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: expected fetch/read data is queued at grant time from a
// reference memory image and compared when the matching valid pulse appears.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [12:0] if_addr, d_addr;
    logic [7:0]  d_wdata;
    logic        if_gnt, if_valid, d_gnt, d_valid;
    logic [15:0] if_instr;
    logic [7:0]  d_rdata;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wd, mem_rd;
    logic        mem_write, mem_read, mem_rst, busy;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_instr(if_instr), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rd(mem_rd), .mem_rst(mem_rst), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            0:       return 8'hE0;
            1:       return 8'h27;
            1000:    return 8'd25;
            1009:    return 8'd20;
            8191:    return 8'h3C;
            default: return 8'(i) ^ 8'h5A;
        endcase
    endfunction

    // Memory under the arbiter: combinational read, write on rising edge.
    logic [7:0] mem [8192];
    logic       loaded = 1'b0;
    assign mem_rd = mem[mem_addr];
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 8192; i++) mem[i] <= init_byte(i);
            loaded <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wd;
        end
    end

    // Reference image: initial contents plus bench-issued writes.
    logic [7:0] ref_wr [int];
    function automatic logic [7:0] ref_rd(input logic [12:0] a);
        if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
        return init_byte(int'(a));
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct { logic is_wr; logic [7:0] data; } d_exp_t;
    logic [15:0] if_q [$];
    d_exp_t      d_q [$];
    int          wcnt = 0;
    int          gn = 0;
    logic [9:0]  glog = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if_q.delete();
            d_q.delete();
        end else begin
            if (if_valid) begin
                if (if_q.size() == 0) chk_val("if_unexpected", 32'd1, 32'd0);
                else chk_val("if_instr", 32'(if_instr), 32'(if_q.pop_front()));
            end
            if (d_valid) begin
                if (d_q.size() == 0) chk_val("d_unexpected", 32'd1, 32'd0);
                else begin
                    d_exp_t e;
                    e = d_q.pop_front();
                    if (!e.is_wr) chk_val("d_rdata", 32'(d_rdata), 32'(e.data));
                end
            end
            if (if_gnt) begin
                logic [12:0] a1;
                a1 = if_addr + 13'd1;
                chk_val("gnt_both", 32'(d_gnt), 32'd0);
                chk_val("if_gnt_overlap", 32'(mem_read | mem_write), 32'd0);
                if_q.push_back({ref_rd(if_addr), ref_rd(a1)});
            end
            if (d_gnt) begin
                d_exp_t e;
                chk_val("d_gnt_overlap", 32'(mem_read | mem_write), 32'd0);
                e.is_wr = d_we;
                e.data  = d_we ? 8'h00 : ref_rd(d_addr);
                if (d_we) ref_wr[int'(d_addr)] = d_wdata;
                d_q.push_back(e);
            end
            if (if_gnt || d_gnt) begin
                if (gn < 10) glog[gn] = if_gnt;
                gn++;
            end
            if (mem_write) begin
                wcnt++;
                chk_val("rd_wr_exclusive", 32'(mem_read), 32'd0);
            end
        end
    end

    task automatic wait_gnt(input bit is_if);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = is_if ? if_gnt : d_gnt;
        end
        if (!seen) chk_val(is_if ? "if_gnt_timeout" : "d_gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic if_access(input logic [12:0] a);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = a;
        wait_gnt(1'b1);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        chk_val("if_hi_read", 32'(mem_read), 32'd1);
        chk_val("if_hi_addr", 32'(mem_addr), 32'(a));
        @(negedge clk);
        chk_val("if_lo_read", 32'(mem_read), 32'd1);
        chk_val("if_lo_addr", 32'(mem_addr), 32'(13'(a + 13'd1)));
        @(negedge clk);
        chk_val("if_valid_t3", 32'(if_valid), 32'd1);
        $display("IF  addr=%0d instr=%04h", a, if_instr);
    endtask

    task automatic d_access(input logic we, input logic [12:0] a, input logic [7:0] wd);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        wait_gnt(1'b0);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        chk_val("d_acc_addr", 32'(mem_addr), 32'(a));
        chk_val("d_acc_read", 32'(mem_read), 32'(!we));
        chk_val("d_acc_write", 32'(mem_write), 32'(we));
        if (we) chk_val("d_acc_wd", 32'(mem_wd), 32'(wd));
        @(negedge clk);
        chk_val("d_valid_t2", 32'(d_valid), 32'd1);
        $display("D   we=%0b addr=%0d wdata=%02h rdata=%02h", we, a, wd, d_rdata);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        if (busy) chk_val("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b1; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        chk_val("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk_val("rst_busy", 32'(busy), 32'd0);
        chk_val("rst_mem_read", 32'(mem_read), 32'd0);
        chk_val("rst_outputs", 32'({if_valid, d_valid, d_gnt, mem_write, mem_addr, mem_wd}), 32'd0);
        chk_val("rst_data", 32'({if_instr, d_rdata}), 32'd0);
        chk_val("rst_mem_rst", 32'(mem_rst), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; if_req = 1'b0;

        if_access(13'd0);
        d_access(1'b0, 13'd1000, 8'h00);
        d_access(1'b0, 13'd1009, 8'h00);
        wcnt = 0;
        d_access(1'b1, 13'd2000, 8'hA5);
        @(negedge clk);
        chk_val("busy_between", 32'(busy), 32'd0);
        chk_val("write_pulse_cnt", 32'(wcnt), 32'd1);
        chk_val("mem_committed", 32'(mem[2000]), 32'hA5);
        chk_val("rdata_hold_after_wr", 32'(d_rdata), 32'd20);
        d_access(1'b0, 13'd2000, 8'h00);
        chk_val("rdata_readback", 32'(d_rdata), 32'hA5);

        // Both requesters held: data wins four times, then fetch is forced.
        @(posedge clk); #1;
        gn = 0; glog = '0;
        if_req = 1'b1; if_addr = 13'd4;
        d_req = 1'b1; d_we = 1'b0; d_addr = 13'd1009;
        for (int i = 0; i < 200 && gn < 10; i++) @(negedge clk);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        wait_idle();
        chk_val("grant_order", 32'(glog), 32'(10'b1000010000));
        $display("STARVE grant_log=%010b", glog);
        chk_val("if_q_drained", 32'(if_q.size()), 32'd0);
        chk_val("d_q_drained", 32'(d_q.size()), 32'd0);

        if_access(13'd8191);

        // Reset during IF_LO abandons the fetch.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 13'd0;
        wait_gnt(1'b1);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_val("pre_rst_lo_addr", 32'(mem_addr), 32'd1);
        rst = 1'b0;
        #1;
        chk_val("midrst_mem_read", 32'(mem_read), 32'd0);
        chk_val("midrst_busy", 32'(busy), 32'd0);
        chk_val("midrst_mem_addr", 32'(mem_addr), 32'd0);
        chk_val("midrst_instr", 32'(if_instr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_val("midrst_no_valid", 32'(if_valid), 32'd0);
        end
        $display("RST asserted during IF_LO, busy=%0b", busy);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_val("post_rst_idle", 32'(busy), 32'd0);
        if_access(13'd0);
        wait_idle();
        chk_val("final_if_q", 32'(if_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 8K x 8 unified memory between two requesters: instruction fetch (IF) and data load/store (D).
- IF reads are 16-bit instructions built from two consecutive bytes. D accesses are single-byte reads or writes.
- The block sits between the CPU control/datapath and `memory`, and is the only driver of the memory's addr/WD/memorywrite/memoryread.

Parameters:
ADDR_W, 13, memory address width (8192 bytes)
DATA_W, 8, memory data width
STARVE_MAX, 4, consecutive D grants allowed while IF waits before IF is forced

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
if_req  in  1  fetch request, held until if_gnt
if_addr  in  ADDR_W  fetch byte address (high byte)
if_gnt  out  1  one-cycle grant; if_addr latched this cycle
if_instr  out  2*DATA_W  fetched instruction {mem[a], mem[a+1]}
if_valid  out  1  one-cycle pulse, if_instr valid
d_req  in  1  data request, held until d_gnt
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  write data
d_gnt  out  1  one-cycle grant; d_we/d_addr/d_wdata latched this cycle
d_rdata  out  DATA_W  read data (holds last value after writes)
d_valid  out  1  one-cycle pulse: read data valid / write done
mem_addr  out  ADDR_W  to memory addr
mem_wd  out  DATA_W  to memory WD
mem_write  out  1  to memory memorywrite
mem_read  out  1  to memory memoryread
mem_rd  in  DATA_W  from memory RD
busy  out  1  1 when state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, starve_cnt=0, every output 0, latched request registers 0.
  - Reset mid-transaction abandons it; no valid pulse follows.
  - An in-flight write is not committed if rst falls before the write edge.
- FSM states: IDLE, IF_HI, IF_LO, D_ACC, RESP.
- Arbitration happens in IDLE and RESP only. It is combinational on req, and the grant is registered-out in the same cycle as the decision.
  - Only d_req: grant D.
  - Only if_req: grant IF.
  - Both, and starve_cnt < STARVE_MAX: grant D, starve_cnt++.
  - Both, and starve_cnt == STARVE_MAX: grant IF.
  - starve_cnt clears on any IF grant, and whenever if_req=0.
- Grant effects: the gnt pulse lasts exactly one cycle; request fields are latched on that edge. The requester drops req (or presents a new request) after gnt.
- IF path (grant at cycle T):
  - T+1 IF_HI: mem_addr=a, mem_read=1, capture mem_rd into if_instr[15:8].
  - T+2 IF_LO: mem_addr=a+1 (mod 2^ADDR_W, 8191 wraps to 0), mem_read=1, capture mem_rd into if_instr[7:0].
  - T+3 RESP: if_valid=1.
- D path (grant at cycle T):
  - T+1 D_ACC: mem_addr=d_addr_q.
    - Read: mem_read=1, capture mem_rd into d_rdata.
    - Write: mem_write=1, mem_wd=d_wdata_q; the memory commits at the rising edge ending T+1.
  - T+2 RESP: d_valid=1.
- RESP arbitrates for the next access, so back-to-back throughput is one access per 2 cycles (D) or 3 cycles (IF).
- Outside IF_HI, IF_LO and D_ACC: mem_read=0, mem_write=0, mem_addr=0, mem_wd=0. mem_read and mem_write are never both 1.
- if_instr and d_rdata hold their value until overwritten.
- The top level drives memory's active-high rst from ~rst.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum arb_state_t {IDLE, IF_HI, IF_LO, D_ACC, RESP};
  - ADDR_W, DATA_W, INSTR_W=16;
  - typedef mem_addr_t logic [12:0].
- One sub-module, mem_arb_prio, contains the arbitration decision plus the starve_cnt register (inputs if_req, d_req, arb_en; outputs gnt_if, gnt_d).

Test Plan:
- Release reset with memory preloaded, if_req at addr 0 → if_gnt at T, mem_read high T+1..T+2, if_valid at T+3 with if_instr=16'hE027.
- d_req read at addr 1000 → d_gnt at T, d_valid at T+2, d_rdata=8'd25; then addr 1009 → 8'd20.
- D write 8'hA5 to addr 2000 (mem_write high exactly 1 cycle), then D read at 2000 → d_rdata=8'hA5; busy=0 between accesses.
- if_req and d_req held continuously, STARVE_MAX=4 → grant order D,D,D,D,IF,D,D,D,D,IF; no grant overlaps an active access.
- IF at addr 8191 → IF_LO drives mem_addr=0; if_instr={mem[8191], mem[0]}.
- rst driven low during IF_LO → mem_read, busy and all outputs go to 0 immediately, no if_valid afterwards, and the FSM restarts from IDLE on release.
